// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: op encodings, flag bit positions,
// the captured result word and the queue occupancy states.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_OR  = 2'd3
   } alu_op_e;

   localparam int FLG_PAR = 4;
   localparam int FLG_OVF = 3;
   localparam int FLG_GT  = 2;
   localparam int FLG_EQ  = 1;
   localparam int FLG_LT  = 0;

   typedef struct packed {
      logic [7:0] y;
      logic [1:0] op;
      logic [4:0] flags;
   } alu_res_t;

   typedef enum logic [1:0] {
      Q_EMPTY   = 2'd0,
      Q_PARTIAL = 2'd1,
      Q_FULL    = 2'd2
   } q_state_e;

endpackage

// File: rtl/alu_res_fifo.sv
// Small in-order FIFO for ALU result words; full/empty come from a state
// register kept in step with the occupancy count.
module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = alu_res_t
) (
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  logic pop_i,
   input  T     wdata_i,
   output T     rdata_o,
   output logic full_o,
   output logic empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   q_state_e         state_q, state_d;
   logic             push, pop;

   assign full_o  = (state_q == Q_FULL);
   assign empty_o = (state_q == Q_EMPTY);
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      push     = push_i && !full_o;
      pop      = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      // DEPTH is a power of two, so pointers wrap by plain overflow
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      unique case (state_q)
         Q_EMPTY:   if (push) state_d = Q_PARTIAL;
         Q_PARTIAL: begin
            if (push && !pop && count_q == LAST)     state_d = Q_FULL;
            else if (pop && !push && count_q == ONE) state_d = Q_EMPTY;
         end
         Q_FULL:    if (pop) state_d = Q_PARTIAL;
         default:   state_d = Q_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= Q_EMPTY;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         if (push) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/alu_result_queue.sv
// Captures ALU results into a small FIFO and keeps saturating event counters.
// Define ALU_RES_STATS_EN to add the greater/equal/less outcome counters.
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_y,
   input  logic [1:0]       in_op,
   input  logic             in_parity,
   input  logic             in_overflow,
   input  logic             in_greater,
   input  logic             in_is_eq,
   input  logic             in_less,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_y,
   output logic [1:0]       out_op,
   output logic [4:0]       out_flags,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] ovf_cnt
`ifdef ALU_RES_STATS_EN
   ,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt
`endif
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != '1) ? v + 1'b1 : v;
   endfunction

   alu_res_t wdata, rdata;
   logic     full, empty, push;
   logic [CNT_W-1:0] ovf_q, ovf_d;

   always_comb begin
      wdata                = '0;
      wdata.y              = in_y;
      wdata.op             = in_op;
      wdata.flags[FLG_PAR] = in_parity;
      wdata.flags[FLG_OVF] = in_overflow;
      wdata.flags[FLG_GT]  = in_greater;
      wdata.flags[FLG_EQ]  = in_is_eq;
      wdata.flags[FLG_LT]  = in_less;
   end

   alu_res_fifo #(.DEPTH(DEPTH), .T(alu_res_t)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid),
      .pop_i   (out_ready),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_y     = rdata.y;
   assign out_op    = rdata.op;
   assign out_flags = rdata.flags;
   assign push      = in_valid && !full;

   // clear takes priority over a same-cycle increment
   assign ovf_d   = stat_clr ? '0 : sat_inc(ovf_q, push && in_overflow);
   assign ovf_cnt = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= '0;
      else     ovf_q <= ovf_d;
   end

`ifdef ALU_RES_STATS_EN
   logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

   assign gt_d   = stat_clr ? '0 : sat_inc(gt_q, push && in_greater);
   assign eq_d   = stat_clr ? '0 : sat_inc(eq_q, push && in_is_eq);
   assign lt_d   = stat_clr ? '0 : sat_inc(lt_q, push && in_less);
   assign gt_cnt = gt_q;
   assign eq_cnt = eq_q;
   assign lt_cnt = lt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gt_q <= '0;
         eq_q <= '0;
         lt_q <= '0;
      end else begin
         gt_q <= gt_d;
         eq_q <= eq_d;
         lt_q <= lt_d;
      end
   end
`endif

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the 8-bit combinational ALU. Captures each ALU result word (y plus parity/overflow/compare flags and the op that produced it) under a valid/ready handshake into a 2-entry FIFO. Presents entries in order to the consumer. Keeps a saturating count of overflow-flagged results and, optionally, compare-outcome statistics.

## Interface
- DEPTH, 2, FIFO entries; legal values 2 or 4, power of two
- CNT_W, 8, width of all event counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ALU result present this cycle
- in_ready  out  1  queue can accept; equals !full
- in_y  in  8  ALU y
- in_op  in  2  op that produced the result
- in_parity, in_overflow, in_greater, in_is_eq, in_less  in  1 each  ALU flags
- out_valid  out  1  head entry valid; equals !empty
- out_ready  in  1  consumer accepts head
- out_y  out  8  head y
- out_op  out  2  head op
- out_flags  out  5  head {parity, overflow, greater, is_eq, less}
- ovf_cnt  out  CNT_W  accepted results with overflow=1, saturating
- stat_clr  in  1  synchronous clear of all counters
- gt_cnt, eq_cnt, lt_cnt  out  CNT_W each  compare-outcome counters (present only with ALU_RES_STATS_EN)

## Operation
- Push: in_valid && in_ready. The 15-bit entry {y, op, flags} is written at wr_ptr, and wr_ptr advances mod DEPTH.
- Pop: out_valid && out_ready. rd_ptr advances mod DEPTH. out_* always reflect the entry at rd_ptr, read from registered storage.
- Occupancy count runs 0..DEPTH:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Full (count==DEPTH):
  - in_ready=0, so no push occurs even if a pop happens the same cycle.
  - in_valid held while full is not lost; the upstream holds its data.
- Empty (count==0): out_valid=0 and out_* hold their last value (don't-care).
- Counters:
  - ovf_cnt increments on every push with in_overflow=1 and saturates at 2^CNT_W−1.
  - stat_clr forces all counters to 0 and wins over a same-cycle increment.
- Pointers wrap naturally. Only count distinguishes full from empty.
- States (derived from count): EMPTY, PARTIAL, FULL.
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push with no pop when count==DEPTH−1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop with no push when count==1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_y=0, out_op=0, out_flags=0, ovf_cnt=0, gt/eq/lt_cnt=0. Pointers and count are 0.
- Latency: a push in cycle N gives out_valid=1 in cycle N+1 when the queue was empty. There is no combinational path from in_* to out_*.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- A counter increment from a push in cycle N is visible in cycle N+1.
- rst asserted mid-stream discards all entries next cycle. A push or pop in the rst cycle has no effect.

## Configuration
- ALU_RES_STATS_EN defined:
  - gt_cnt, eq_cnt and lt_cnt exist.
  - Each increments on a push whose in_greater, in_is_eq or in_less respectively is 1.
  - Each saturates and is cleared by stat_clr.
- Undefined: the three ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - op encodings
  - the flag-vector bit positions (PAR=4, OVF=3, GT=2, EQ=1, LT=0)
  - the alu_res_t packed struct {y[7:0], op[1:0], flags[4:0]}
- One sub-module, alu_res_fifo, holds storage, pointers and count, and is parameterised on DEPTH and the entry type.
- Counters live in the top level.

## Test plan
- Reset, then a single push of y=0x5A, op=2, flags=5'b01010 with out_ready=1 → out_valid=1 the next cycle with the same values, and empty again one cycle later. ovf_cnt=1.
- Three pushes with out_ready=0 (DEPTH=2) → in_ready=0 after the second push; the third is held. Then raise out_ready → entries drain in order and the third is accepted when in_ready returns.
- Continuous push and pop at count=1 for 20 cycles → count stays 1, no entry is dropped or duplicated, and pointers wrap.
- 300 pushes all with overflow=1 → ovf_cnt saturates at 255. Assert stat_clr together with a push → ovf_cnt=0.
- With ALU_RES_STATS_EN: push results 4 times with greater=1, 2 with is_eq=1, 1 with less=1 → gt_cnt=4, eq_cnt=2, lt_cnt=1.
- Assert rst while full → next cycle out_valid=0, in_ready=1, all counters 0.
